// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: valid/ready stage boundary with optional skid entry.
// Bubbles carry zero control and rd address so they can never write the register file.
module elastic_pipe_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 2,
    parameter int CTRL_WIDTH = 2,
    parameter int SKID_EN    = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [4:0]                   in_rd_addr,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [4:0]                   out_rd_addr,
    output logic [CTRL_WIDTH-1:0]        out_ctrl,
    output logic [1:0]                   occupancy,
    output logic [CNT_WIDTH-1:0]         stall_count
);
    localparam int PW = NUM_CH * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    state_t                state_reg;
    logic [PW-1:0]         main_data_reg;
    logic [4:0]            main_rd_reg;
    logic [CTRL_WIDTH-1:0] main_ctrl_reg;
    logic [CNT_WIDTH-1:0]  stall_cnt_reg;

    logic [PW-1:0]         skid_data;
    logic [4:0]            skid_rd;
    logic [CTRL_WIDTH-1:0] skid_ctrl;

    logic in_fire;
    logic out_fire;

    assign out_valid = (state_reg != S_EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    generate
        if (SKID_EN != 0) begin : g_skid
            logic [PW-1:0]         skid_data_reg;
            logic [4:0]            skid_rd_reg;
            logic [CTRL_WIDTH-1:0] skid_ctrl_reg;
            logic                  skid_load;

            // in_ready depends only on state, so out_ready never reaches it combinationally
            assign in_ready  = (state_reg != S_SKID);
            assign skid_load = !flush && (state_reg == S_FULL) && in_fire && !out_fire;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skid_data_reg <= '0;
                    skid_rd_reg   <= '0;
                    skid_ctrl_reg <= '0;
                end else if (flush) begin
                    skid_data_reg <= '0;
                    skid_rd_reg   <= '0;
                    skid_ctrl_reg <= '0;
                end else if (skid_load) begin
                    skid_data_reg <= in_data;
                    skid_rd_reg   <= in_rd_addr;
                    skid_ctrl_reg <= in_ctrl;
                end
            end

            assign skid_data = skid_data_reg;
            assign skid_rd   = skid_rd_reg;
            assign skid_ctrl = skid_ctrl_reg;
        end else begin : g_no_skid
            assign in_ready  = !out_valid || out_ready;
            assign skid_data = '0;
            assign skid_rd   = '0;
            assign skid_ctrl = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_EMPTY;
            main_data_reg <= '0;
            main_rd_reg   <= '0;
            main_ctrl_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (out_valid && !out_ready && !flush && (stall_cnt_reg != {CNT_WIDTH{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

            if (flush) begin
                state_reg     <= S_EMPTY;
                main_data_reg <= '0;
                main_rd_reg   <= '0;
                main_ctrl_reg <= '0;
            end else begin
                case (state_reg)
                    S_EMPTY: begin
                        if (in_fire) begin
                            state_reg     <= S_FULL;
                            main_data_reg <= in_data;
                            main_rd_reg   <= in_rd_addr;
                            main_ctrl_reg <= in_ctrl;
                        end
                    end
                    S_FULL: begin
                        if (in_fire && out_fire) begin
                            main_data_reg <= in_data;
                            main_rd_reg   <= in_rd_addr;
                            main_ctrl_reg <= in_ctrl;
                        end else if (in_fire) begin
                            // only reachable with a skid entry: without one, in_fire implies out_fire
                            state_reg <= S_SKID;
                        end else if (out_fire) begin
                            // data is left as-is; rd/ctrl must read zero on a bubble
                            state_reg     <= S_EMPTY;
                            main_rd_reg   <= '0;
                            main_ctrl_reg <= '0;
                        end
                    end
                    S_SKID: begin
                        if (out_fire) begin
                            state_reg     <= S_FULL;
                            main_data_reg <= skid_data;
                            main_rd_reg   <= skid_rd;
                            main_ctrl_reg <= skid_ctrl;
                        end
                    end
                    default: state_reg <= S_EMPTY;
                endcase
            end
        end
    end

    assign out_data    = main_data_reg;
    assign out_rd_addr = main_rd_reg;
    assign out_ctrl    = main_ctrl_reg;
    assign stall_count = stall_cnt_reg;
    assign occupancy   = (state_reg == S_SKID) ? 2'd2 :
                         (state_reg == S_FULL) ? 2'd1 : 2'd0;

endmodule
